// File: rtl/cr_huf_compPKG.sv
// Shared types and widths for the Huffman compressor short-tree header reader.
package cr_huf_compPKG;

    localparam int unsigned CREOLE_HC_SHORT_DAT_WIDTH      = 5;
    localparam int unsigned CREOLE_HC_SHORT_SYM_ADDR_WIDTH = 5;
    localparam int unsigned CREOLE_HC_SYM_CODELENGTH       = 4;
    localparam int unsigned CREOLE_HC_SEQID_WIDTH          = 4;

    // End-of-build notice; MIDDLE means no notice this cycle.
    typedef enum logic [1:0] {
        MIDDLE    = 2'd0,
        PASS1_EOB = 2'd1,
        PASS2_EOB = 2'd2,
        FINAL_EOB = 2'd3
    } e_pipe_eob;

    // Header reader control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } e_hw_rdr_state;

    // One reader output entry at the default widths.
    typedef struct packed {
        logic [2*CREOLE_HC_SHORT_DAT_WIDTH-1:0] sym;
        logic [2*CREOLE_HC_SYM_CODELENGTH-1:0]  dpth;
        logic [1:0]                             val;
        logic                                   last;
        logic                                   err;
        logic [CREOLE_HC_SEQID_WIDTH-1:0]       seq_id;
    } s_hw_rdr_entry;

endpackage

// File: rtl/cr_huf_comp_hw_rdr_fifo.sv
// Small synchronous FIFO with occupancy count; pointers carry an extra wrap bit.
module cr_huf_comp_hw_rdr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_c     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign do_pop_c   = pop_i && !empty_o;
    assign do_push_c  = push_i && (!full_c || do_pop_c);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update; a full FIFO may still take a push when popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_c && !pop_i))
        else $error("push into full reader FIFO");

endmodule

// File: rtl/cr_huf_comp_hw_short_rdr.sv
// Reads a finished short Huffman tree out of its builder into a credit-controlled FIFO.
module cr_huf_comp_hw_short_rdr
    import cr_huf_compPKG::*;
#(
    parameter int unsigned DAT_WIDTH      = CREOLE_HC_SHORT_DAT_WIDTH,
    parameter int unsigned SYM_ADDR_WIDTH = CREOLE_HC_SHORT_SYM_ADDR_WIDTH,
    parameter int unsigned DPTH_WIDTH     = CREOLE_HC_SYM_CODELENGTH,
    parameter int unsigned SEQID_WIDTH    = CREOLE_HC_SEQID_WIDTH,
    parameter int unsigned RD_LAT         = 2,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  e_pipe_eob                   ht_hw_eob,
    input  logic [SEQID_WIDTH-1:0]      ht_hw_seq_id,
    input  logic                        ht_hw_zero_symbols,
    input  logic                        ht_hw_build_error,
    input  logic [DAT_WIDTH-1:0]        ht_hw_sym_lo,
    input  logic [DAT_WIDTH-1:0]        ht_hw_sym_hi,
    input  logic [2*DPTH_WIDTH-1:0]     ht_hw_sym_dpth,
    input  logic [1:0]                  ht_hw_sym_sort_freq_val,
    output logic                        hw_ht_sym_freq_rd,
    output logic [SYM_ADDR_WIDTH-2:0]   hw_ht_sym_freq_rd_addr,
    output logic [SEQID_WIDTH-1:0]      hw_ht_sym_freq_seq_id,
    output logic                        hw_ht_sym_freq_rd_done,
    output logic                        hw_ht_not_ready,
    output logic                        rdr_enc_valid,
    input  logic                        rdr_enc_ready,
    output logic [2*DAT_WIDTH-1:0]      rdr_enc_sym,
    output logic [2*DPTH_WIDTH-1:0]     rdr_enc_dpth,
    output logic [1:0]                  rdr_enc_val,
    output logic                        rdr_enc_last,
    output logic                        rdr_enc_err,
    output logic [SEQID_WIDTH-1:0]      rdr_enc_seq_id
);

    localparam int unsigned ADDR_W = SYM_ADDR_WIDTH - 1;
    localparam int unsigned NUM_RD = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [2*DAT_WIDTH-1:0]  sym;
        logic [2*DPTH_WIDTH-1:0] dpth;
        logic [1:0]              val;
        logic                    last;
        logic                    err;
        logic [SEQID_WIDTH-1:0]  seq_id;
    } s_entry_t;

    e_hw_rdr_state          state_q, state_d;
    logic                   rd_q, rd_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [SEQID_WIDTH-1:0] seq_q, seq_d;
    logic                   done_q, done_d;
    logic                   not_ready_q;
    logic [RD_LAT-1:0]      dly_vld_q;
    logic [RD_LAT-1:0]      dly_last_q;

    logic                   eob_c;
    logic                   tree_err_c;
    logic                   err_push_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   credit_ok_c;
    logic                   last_addr_c;
    logic [CNT_W-1:0]       fifo_cnt;
    logic [CNT_W-1:0]       inflight_c;
    logic [CNT_W-1:0]       occ_c;
    logic                   fifo_empty;
    s_entry_t               push_entry_c;
    s_entry_t               head;

    assign eob_c       = (ht_hw_eob != MIDDLE);
    assign tree_err_c  = ht_hw_build_error | ht_hw_zero_symbols;
    assign last_addr_c = (addr_q == ADDR_W'(NUM_RD - 1));
    assign pop_c       = !fifo_empty && rdr_enc_ready;
    assign push_c      = dly_vld_q[RD_LAT-1] | err_push_c;

    // Reads still travelling through the builder, including the one on the bus now.
    always_comb begin
        inflight_c = CNT_W'(rd_q);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight_c = inflight_c + CNT_W'(dly_vld_q[i]);
        end
    end

    // Slots claimed once this cycle's pop retires; another read fits if below depth.
    assign occ_c       = fifo_cnt + inflight_c - CNT_W'(pop_c);
    assign credit_ok_c = (occ_c < CNT_W'(FIFO_DEPTH));

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        rd_d       = 1'b0;
        addr_d     = addr_q;
        seq_d      = seq_q;
        done_d     = 1'b0;
        err_push_c = 1'b0;
        if (rd_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (eob_c) begin
                    seq_d  = ht_hw_seq_id;
                    addr_d = '0;
                    if (tree_err_c) begin
                        err_push_c = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (rd_q && last_addr_c) begin
                    state_d = DRAIN;
                end else begin
                    rd_d = credit_ok_c;
                end
            end
            DRAIN: begin
                if (occ_c == '0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and builder-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            seq_q       <= '0;
            done_q      <= 1'b0;
            not_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            seq_q       <= seq_d;
            done_q      <= done_d;
            not_ready_q <= (state_d != IDLE);
        end
    end

    // Return-path delay line matching the builder read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_vld_q  <= '0;
            dly_last_q <= '0;
        end else begin
            dly_vld_q[0]  <= rd_q;
            dly_last_q[0] <= rd_q && last_addr_c;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                dly_vld_q[i]  <= dly_vld_q[i-1];
                dly_last_q[i] <= dly_last_q[i-1];
            end
        end
    end

    // Entry to store: returned tree data, or a lone error marker for a failed build.
    always_comb begin
        push_entry_c.sym    = {ht_hw_sym_hi, ht_hw_sym_lo};
        push_entry_c.dpth   = ht_hw_sym_dpth;
        push_entry_c.val    = ht_hw_sym_sort_freq_val;
        push_entry_c.last   = dly_last_q[RD_LAT-1];
        push_entry_c.err    = 1'b0;
        push_entry_c.seq_id = seq_q;
        if (err_push_c) begin
            push_entry_c.sym    = '0;
            push_entry_c.dpth   = '0;
            push_entry_c.val    = 2'b00;
            push_entry_c.last   = 1'b1;
            push_entry_c.err    = 1'b1;
            push_entry_c.seq_id = ht_hw_seq_id;
        end
    end

    cr_huf_comp_hw_rdr_fifo #(
        .WIDTH ($bits(s_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .push_data_i (push_entry_c),
        .pop_i       (pop_c),
        .pop_data_o  (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign hw_ht_sym_freq_rd      = rd_q;
    assign hw_ht_sym_freq_rd_addr = addr_q;
    assign hw_ht_sym_freq_seq_id  = seq_q;
    assign hw_ht_sym_freq_rd_done = done_q;
    assign hw_ht_not_ready        = not_ready_q;

    // Head entry, zeroed while the FIFO is empty.
    assign rdr_enc_valid  = !fifo_empty;
    assign rdr_enc_sym    = rdr_enc_valid ? head.sym    : '0;
    assign rdr_enc_dpth   = rdr_enc_valid ? head.dpth   : '0;
    assign rdr_enc_val    = rdr_enc_valid ? head.val    : '0;
    assign rdr_enc_last   = rdr_enc_valid ? head.last   : 1'b0;
    assign rdr_enc_err    = rdr_enc_valid ? head.err    : 1'b0;
    assign rdr_enc_seq_id = rdr_enc_valid ? head.seq_id : '0;

    eob_when_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
        eob_c |-> (state_q == IDLE))
        else $warning("eob ignored: short tree reader busy");

endmodule

// File: tb/tb_cr_huf_comp_hw_short_rdr.sv
// Scoreboard bench for the short tree header reader with a fixed-latency builder model.
module tb_cr_huf_comp_hw_short_rdr;
    import cr_huf_compPKG::*;

    localparam int unsigned DW = 5;
    localparam int unsigned SAW = 5;
    localparam int unsigned PW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned NRD = 16;

    typedef struct packed {
        logic [2*DW-1:0] sym;
        logic [2*PW-1:0] dpth;
        logic [1:0]      val;
        logic            last;
        logic            err;
        logic [SW-1:0]   seq;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    e_pipe_eob       ht_hw_eob = MIDDLE;
    logic [SW-1:0]   ht_hw_seq_id = '0;
    logic            ht_hw_zero_symbols = 1'b0;
    logic            ht_hw_build_error = 1'b0;
    logic [DW-1:0]   ht_hw_sym_lo;
    logic [DW-1:0]   ht_hw_sym_hi;
    logic [2*PW-1:0] ht_hw_sym_dpth;
    logic [1:0]      ht_hw_sym_sort_freq_val;
    logic            hw_ht_sym_freq_rd;
    logic [SAW-2:0]  hw_ht_sym_freq_rd_addr;
    logic [SW-1:0]   hw_ht_sym_freq_seq_id;
    logic            hw_ht_sym_freq_rd_done;
    logic            hw_ht_not_ready;
    logic            rdr_enc_valid;
    logic            rdr_enc_ready = 1'b1;
    logic [2*DW-1:0] rdr_enc_sym;
    logic [2*PW-1:0] rdr_enc_dpth;
    logic [1:0]      rdr_enc_val;
    logic            rdr_enc_last;
    logic            rdr_enc_err;
    logic [SW-1:0]   rdr_enc_seq_id;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   rd_cyc[$];
    int   pop_cyc[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_pop_cyc = 0;
    int   exp_addr = 0;
    int   t_eob = 0;
    int   rd_base = 0;
    int   pop_base = 0;
    int   done_base = 0;
    logic [1:0] fv = 2'b11;

    logic [1:0]     rdp;
    logic [SAW-2:0] ap0, ap1;

    cr_huf_comp_hw_short_rdr #(
        .DAT_WIDTH(DW), .SYM_ADDR_WIDTH(SAW), .DPTH_WIDTH(PW),
        .SEQID_WIDTH(SW), .RD_LAT(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ht_hw_eob(ht_hw_eob), .ht_hw_seq_id(ht_hw_seq_id),
        .ht_hw_zero_symbols(ht_hw_zero_symbols), .ht_hw_build_error(ht_hw_build_error),
        .ht_hw_sym_lo(ht_hw_sym_lo), .ht_hw_sym_hi(ht_hw_sym_hi),
        .ht_hw_sym_dpth(ht_hw_sym_dpth), .ht_hw_sym_sort_freq_val(ht_hw_sym_sort_freq_val),
        .hw_ht_sym_freq_rd(hw_ht_sym_freq_rd), .hw_ht_sym_freq_rd_addr(hw_ht_sym_freq_rd_addr),
        .hw_ht_sym_freq_seq_id(hw_ht_sym_freq_seq_id), .hw_ht_sym_freq_rd_done(hw_ht_sym_freq_rd_done),
        .hw_ht_not_ready(hw_ht_not_ready),
        .rdr_enc_valid(rdr_enc_valid), .rdr_enc_ready(rdr_enc_ready),
        .rdr_enc_sym(rdr_enc_sym), .rdr_enc_dpth(rdr_enc_dpth), .rdr_enc_val(rdr_enc_val),
        .rdr_enc_last(rdr_enc_last), .rdr_enc_err(rdr_enc_err), .rdr_enc_seq_id(rdr_enc_seq_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Builder model: data for a read appears two cycles after the strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdp <= '0;
            ap0 <= '0;
            ap1 <= '0;
        end else begin
            rdp[0] <= hw_ht_sym_freq_rd;
            ap0    <= hw_ht_sym_freq_rd_addr;
            rdp[1] <= rdp[0];
            ap1    <= ap0;
        end
    end

    assign ht_hw_sym_lo            = rdp[1] ? DW'(2 * ap1)     : '0;
    assign ht_hw_sym_hi            = rdp[1] ? DW'(2 * ap1 + 1) : '0;
    assign ht_hw_sym_dpth          = rdp[1] ? {PW'(15 - ap1), PW'(ap1)} : '0;
    assign ht_hw_sym_sort_freq_val = rdp[1] ? fv : 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({hw_ht_sym_freq_rd, hw_ht_sym_freq_rd_addr, hw_ht_sym_freq_seq_id,
                    hw_ht_sym_freq_rd_done, hw_ht_not_ready, rdr_enc_valid, rdr_enc_sym,
                    rdr_enc_dpth, rdr_enc_val, rdr_enc_last, rdr_enc_err, rdr_enc_seq_id});
    endfunction

    // Monitor: read address order, entry scoreboard, done pulses.
    always @(negedge clk) begin
        exp_t act;
        if (rst_n) begin
            if (!hw_ht_not_ready) exp_addr = 0;
            if (hw_ht_sym_freq_rd) begin
                chk("rd_addr", 64'(hw_ht_sym_freq_rd_addr), 64'(exp_addr));
                exp_addr++;
                rd_cyc.push_back(cyc);
            end
            if (rdr_enc_valid && rdr_enc_ready) begin
                act = {rdr_enc_sym, rdr_enc_dpth, rdr_enc_val, rdr_enc_last, rdr_enc_err, rdr_enc_seq_id};
                pop_cyc.push_back(cyc);
                if (rdr_enc_last) last_pop_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry act=%0h req=none", act);
                end else begin
                    chk("entry", 64'(act), 64'(sb.pop_front()));
                end
            end
            if (hw_ht_sym_freq_rd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_eob(input logic [SW-1:0] seq, input logic berr, input logic zs);
        exp_t e;
        @(posedge clk); #1;
        ht_hw_eob          = PASS1_EOB;
        ht_hw_seq_id       = seq;
        ht_hw_build_error  = berr;
        ht_hw_zero_symbols = zs;
        t_eob     = cyc;
        rd_base   = rd_cyc.size();
        pop_base  = pop_cyc.size();
        done_base = done_cnt;
        if (berr || zs) begin
            e = '{sym: '0, dpth: '0, val: 2'b00, last: 1'b1, err: 1'b1, seq: seq};
            sb.push_back(e);
        end else begin
            for (int a = 0; a < int'(NRD); a++) begin
                e.sym  = {DW'(2 * a + 1), DW'(2 * a)};
                e.dpth = {PW'(15 - a), PW'(a)};
                e.val  = fv;
                e.last = (a == int'(NRD) - 1);
                e.err  = 1'b0;
                e.seq  = seq;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        ht_hw_eob          = MIDDLE;
        ht_hw_build_error  = 1'b0;
        ht_hw_zero_symbols = 1'b0;
        @(negedge clk);
        chk("not_ready_rise", 64'(hw_ht_not_ready), 64'd1);
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (done_cnt == done_base && n < 300) begin
            @(posedge clk); #1;
            if (rnd) rdr_enc_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            n++;
        end
        chk("done_count", 64'(done_cnt - done_base), 64'd1);
        chk("done_after_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
        @(negedge clk);
        chk("not_ready_fall", 64'(hw_ht_not_ready), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        rdr_enc_ready = 1'b1;
    endtask

    initial begin
        int r_cyc;
        int n;
        #1;
        chk("reset_outs", all_outs(), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", all_outs(), 64'd0);

        // Full tree, ready held high.
        fv = 2'b11;
        send_eob(4'd5, 1'b0, 1'b0);
        wait_done(1'b0);
        chk("t1_reads", 64'(rd_cyc.size() - rd_base), 64'd16);
        chk("t1_first_rd", 64'(rd_cyc[rd_base]), 64'(t_eob + 1));
        chk("t1_last_rd", 64'(rd_cyc[rd_base + 15]), 64'(t_eob + 16));

        // Build error: single error entry, no reads.
        send_eob(4'd9, 1'b1, 1'b0);
        wait_done(1'b0);
        chk("t2_reads", 64'(rd_cyc.size() - rd_base), 64'd0);

        // Zero-symbol tree takes the same error path.
        send_eob(4'd10, 1'b0, 1'b1);
        wait_done(1'b0);
        chk("t2z_reads", 64'(rd_cyc.size() - rd_base), 64'd0);

        // Downstream stalled: credit stops reads at FIFO depth.
        rdr_enc_ready = 1'b0;
        send_eob(4'd3, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("t3_stall_reads", 64'(rd_cyc.size() - rd_base), 64'd4);
        chk("t3_stall_valid", 64'(rdr_enc_valid), 64'd1);
        chk("t3_stall_busy", 64'(hw_ht_not_ready), 64'd1);
        @(posedge clk); #1;
        rdr_enc_ready = 1'b1;
        r_cyc = cyc;
        wait_done(1'b0);
        chk("t3_first_pop", 64'(pop_cyc[pop_base]), 64'(r_cyc));
        chk("t3_resume_rd", 64'(rd_cyc[rd_base + 4]), 64'(r_cyc + 1));
        chk("t3_reads", 64'(rd_cyc.size() - rd_base), 64'd16);

        // Random backpressure with a single-lane valid pattern.
        fv = 2'b01;
        send_eob(4'd11, 1'b0, 1'b0);
        wait_done(1'b1);
        chk("t4_reads", 64'(rd_cyc.size() - rd_base), 64'd16);

        // Second eob while busy is ignored.
        fv = 2'b11;
        send_eob(4'd6, 1'b0, 1'b0);
        @(posedge clk); #1;
        ht_hw_eob    = PASS2_EOB;
        ht_hw_seq_id = 4'd12;
        @(posedge clk); #1;
        ht_hw_eob    = MIDDLE;
        ht_hw_seq_id = '0;
        @(negedge clk);
        chk("t5_busy", 64'(hw_ht_not_ready), 64'd1);
        chk("t5_seq_kept", 64'(hw_ht_sym_freq_seq_id), 64'd6);
        wait_done(1'b0);
        chk("t5_reads", 64'(rd_cyc.size() - rd_base), 64'd16);

        // Reset in the middle of a tree.
        send_eob(4'd7, 1'b0, 1'b0);
        n = 0;
        while ((rd_cyc.size() - rd_base) < 7 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t6_reached_rd7", 64'(rd_cyc.size() - rd_base), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outs", all_outs(), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_no_done", 64'(done_cnt - done_base), 64'd0);
        send_eob(4'd8, 1'b0, 1'b0);
        wait_done(1'b0);
        chk("t6_reads", 64'(rd_cyc.size() - rd_base), 64'd16);
        chk("t6_first_rd", 64'(rd_cyc[rd_base]), 64'(t_eob + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
